pf_lpddr3_dqsw_training_ctrl: RTL and testbench

Fabric-side sequencer that drives the delay-line and eye-monitor controls of one LPDDR3 DQSW training IOD lane and consumes its returned RX data and flags. It sweeps the delay line tap by tap, samples the loopback data at each tap, and stops at the first clean 0→1 transition. The result is reported to the PHY training engine as EDGE_TAP, and the IOD is left parked at that tap.

---
 rtl/pf_lpddr3_dqsw_training_ctrl_if.sv | 45 ++++
 rtl/pf_lpddr3_dqsw_training_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pf_lpddr3_dqsw_training_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pf_lpddr3_dqsw_training_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pf_lpddr3_dqsw_training_ctrl_if
// Desc     : Control/data bundle between the DQSW training sequencer and one IOD lane.
// Revision : 1.0
// ============================================================================
interface pf_lpddr3_dqsw_training_ctrl_if;
    logic [1:0] TX_DATA_0;
    logic [1:0] OE_DATA_0;
    logic       DELAY_LINE_LOAD_0;
    logic       DELAY_LINE_MOVE_0;
    logic       DELAY_LINE_DIRECTION_0;
    logic       EYE_MONITOR_CLEAR_FLAGS_0;
    logic       EYE_MONITOR_EARLY_0;
    logic       EYE_MONITOR_LATE_0;
    logic       DELAY_LINE_OUT_OF_RANGE_0;
    logic [1:0] RX_DATA_0;

    modport master (
        output TX_DATA_0,
        output OE_DATA_0,
        output DELAY_LINE_LOAD_0,
        output DELAY_LINE_MOVE_0,
        output DELAY_LINE_DIRECTION_0,
        output EYE_MONITOR_CLEAR_FLAGS_0,
        input  EYE_MONITOR_EARLY_0,
        input  EYE_MONITOR_LATE_0,
        input  DELAY_LINE_OUT_OF_RANGE_0,
        input  RX_DATA_0
    );

    modport slave (
        input  TX_DATA_0,
        input  OE_DATA_0,
        input  DELAY_LINE_LOAD_0,
        input  DELAY_LINE_MOVE_0,
        input  DELAY_LINE_DIRECTION_0,
        input  EYE_MONITOR_CLEAR_FLAGS_0,
        output EYE_MONITOR_EARLY_0,
        output EYE_MONITOR_LATE_0,
        output DELAY_LINE_OUT_OF_RANGE_0,
        output RX_DATA_0
    );
endinterface
`default_nettype wire

// File: rtl/pf_lpddr3_dqsw_training_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pf_lpddr3_dqsw_training_ctrl
// Desc     : Sweeps the IOD delay line and parks it on the first clean 0->1 tap.
// Revision : 1.0
// ============================================================================
module pf_lpddr3_dqsw_training_ctrl #(
    parameter int MAX_TAPS      = 128,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_CYCLES = 16
) (
    input  logic                                  FAB_CLK,
    input  logic                                  SYNC_RST,
    input  logic                                  START,
    pf_lpddr3_dqsw_training_ctrl_if.master        iod,
    output logic                                  BUSY,
    output logic                                  DONE,
    output logic                                  FAIL,
    output logic [7:0]                            TAP_COUNT,
    output logic [7:0]                            EDGE_TAP
);

    localparam int c_CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SAMPLE_LAST = c_CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [7:0]         c_LAST_TAP    = 8'(MAX_TAPS - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_CLEAR  = 4'd2,
        S_SETTLE = 4'd3,
        S_SAMPLE = 4'd4,
        S_EVAL   = 4'd5,
        S_STEP   = 4'd6,
        S_DONE   = 4'd7,
        S_FAIL   = 4'd8
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [7:0]           r_tap;
    logic [7:0]           r_edge;
    logic                 r_seen_zero;
    logic                 r_first;
    logic                 r_mismatch;
    logic                 r_flag;
    logic                 r_rx0_q;
    logic                 r_flag_q;
    logic                 r_oor_q;
    logic                 w_load;
    logic                 w_move;
    logic                 w_clear;
    logic                 w_busy;
    logic                 w_clean;
    logic                 w_edge_found;
    logic                 w_step_fail;
    logic                 w_unused_rx1;

    assign w_unused_rx1 = iod.RX_DATA_0[1];

    assign w_clean      = !r_mismatch && !r_flag;
    assign w_edge_found = w_clean && r_first && r_seen_zero;
    assign w_step_fail  = (r_tap == c_LAST_TAP) || r_oor_q;

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_move      = 1'b0;
        w_clear     = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                w_busy = 1'b0;
                if (START) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                w_clear     = 1'b1;
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    w_state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (r_cnt == c_SAMPLE_LAST) begin
                    w_state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                w_state_nxt = w_edge_found ? S_DONE : S_STEP;
            end
            S_STEP: begin
                // A range violation ends the sweep instead of moving further.
                if (w_step_fail) begin
                    w_state_nxt = S_FAIL;
                end else begin
                    w_move      = 1'b1;
                    w_state_nxt = S_CLEAR;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            r_cnt       <= '0;
            r_tap       <= '0;
            r_edge      <= '0;
            r_seen_zero <= 1'b0;
            r_first     <= 1'b0;
            r_mismatch  <= 1'b0;
            r_flag      <= 1'b0;
            r_rx0_q     <= 1'b0;
            r_flag_q    <= 1'b0;
            r_oor_q     <= 1'b0;
        end else begin
            r_rx0_q  <= iod.RX_DATA_0[0];
            r_flag_q <= iod.EYE_MONITOR_EARLY_0 | iod.EYE_MONITOR_LATE_0;
            r_oor_q  <= iod.DELAY_LINE_OUT_OF_RANGE_0;

            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state == S_SETTLE || r_state == S_SAMPLE) begin
                r_cnt <= r_cnt + 1'b1;
            end

            case (r_state)
                S_LOAD: begin
                    r_tap       <= '0;
                    r_seen_zero <= 1'b0;
                end
                S_SAMPLE: begin
                    if (r_cnt == '0) begin
                        r_first    <= r_rx0_q;
                        r_mismatch <= 1'b0;
                        r_flag     <= r_flag_q;
                    end else begin
                        r_mismatch <= r_mismatch | (r_rx0_q != r_first);
                        r_flag     <= r_flag | r_flag_q;
                    end
                end
                S_EVAL: begin
                    // Only a clean zero arms edge detection; noisy taps leave it untouched.
                    if (w_clean && !r_first) begin
                        r_seen_zero <= 1'b1;
                    end
                    if (w_edge_found) begin
                        r_edge <= r_tap;
                    end
                end
                S_STEP: begin
                    if (!w_step_fail && r_tap != 8'hFF) begin
                        r_tap <= r_tap + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign iod.TX_DATA_0                 = w_busy ? 2'b01 : 2'b00;
    assign iod.OE_DATA_0                 = w_busy ? 2'b11 : 2'b00;
    assign iod.DELAY_LINE_LOAD_0         = w_load;
    assign iod.DELAY_LINE_MOVE_0         = w_move;
    assign iod.DELAY_LINE_DIRECTION_0    = 1'b1;
    assign iod.EYE_MONITOR_CLEAR_FLAGS_0 = w_clear;

    assign BUSY      = w_busy;
    assign DONE      = (r_state == S_DONE);
    assign FAIL      = (r_state == S_FAIL);
    assign TAP_COUNT = r_tap;
    assign EDGE_TAP  = r_edge;

endmodule
`default_nettype wire

// File: tb/tb_pf_lpddr3_dqsw_training_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pf_lpddr3_dqsw_training_ctrl
// Desc     : Scoreboard bench for the DQSW training sequencer with an IOD RX model.
// Revision : 1.0
// ============================================================================
module tb_pf_lpddr3_dqsw_training_ctrl;

    typedef struct {
        string      name;
        logic       done;
        logic       fail;
        logic [7:0] tap;
        logic [7:0] edg;
        int         moves;
        int         loads;
        int         clears;
    } exp_t;

    typedef struct {
        string       name;
        int          inst;
        logic [26:0] vec;
    } snap_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, start0, start1;
    logic busy0, done0, fail0, busy1, done1, fail1;
    logic [7:0] tapc0, edge0, tapc1, edge1;

    pf_lpddr3_dqsw_training_ctrl_if ifc0();
    pf_lpddr3_dqsw_training_ctrl_if ifc1();

    pf_lpddr3_dqsw_training_ctrl u_dut0 (
        .FAB_CLK(clk), .SYNC_RST(rst0), .START(start0), .iod(ifc0.master),
        .BUSY(busy0), .DONE(done0), .FAIL(fail0), .TAP_COUNT(tapc0), .EDGE_TAP(edge0)
    );

    pf_lpddr3_dqsw_training_ctrl #(.MAX_TAPS(16)) u_dut1 (
        .FAB_CLK(clk), .SYNC_RST(rst1), .START(start1), .iod(ifc1.master),
        .BUSY(busy1), .DONE(done1), .FAIL(fail1), .TAP_COUNT(tapc1), .EDGE_TAP(edge1)
    );

    // Packed view: busy,done,fail,load,move,clear,dir,tx[1:0],oe[1:0],tap[7:0],edge[7:0]
    logic [26:0] snapv [2];
    logic        rstv  [2];
    assign snapv[0] = {busy0, done0, fail0, ifc0.DELAY_LINE_LOAD_0, ifc0.DELAY_LINE_MOVE_0,
                       ifc0.EYE_MONITOR_CLEAR_FLAGS_0, ifc0.DELAY_LINE_DIRECTION_0,
                       ifc0.TX_DATA_0, ifc0.OE_DATA_0, tapc0, edge0};
    assign snapv[1] = {busy1, done1, fail1, ifc1.DELAY_LINE_LOAD_0, ifc1.DELAY_LINE_MOVE_0,
                       ifc1.EYE_MONITOR_CLEAR_FLAGS_0, ifc1.DELAY_LINE_DIRECTION_0,
                       ifc1.TX_DATA_0, ifc1.OE_DATA_0, tapc1, edge1};
    assign rstv[0] = rst0;
    assign rstv[1] = rst1;

    exp_t  cq0[$];
    exp_t  cq1[$];
    snap_t sq[$];

    int   errors = 0;
    int   checks = 0;
    int   m0 = 0;
    int   m1 = 0;
    int   mv[2], ld[2], cl[2], mtap[2];
    logic prev_end[2];
    logic tog = 1'b0;
    logic multi_err = 1'b0;
    logic fin_req = 1'b0;
    exp_t  e_m;
    snap_t s_m;
    logic [2:0] rx_m;

    function automatic logic [26:0] mk(input logic busy, input logic done, input logic fail,
                                       input logic load, input logic [7:0] tap, input logic [7:0] edg);
        return {busy, done, fail, load, 1'b0, 1'b0, 1'b1,
                busy ? 2'b01 : 2'b00, busy ? 2'b11 : 2'b00, tap, edg};
    endfunction

    // IOD model for lane 0: returns {early, late, rx0} for the current tap.
    function automatic logic [2:0] model0(input int m, input int t, input logic tg);
        logic e, l, r;
        e = 1'b0;
        l = 1'b0;
        r = 1'b0;
        case (m)
            1: r = (t >= 5);
            2: begin
                if (t == 2) begin
                    r = 1'b1;
                    l = 1'b1;
                end else if (t == 3 || t == 4) begin
                    r = tg;
                end else if (t == 5) begin
                    r = 1'b1;
                    e = 1'b1;
                end else begin
                    r = (t >= 6);
                end
            end
            3: r = (t < 10) || (t >= 20);
            default: r = 1'b0;
        endcase
        return {e, l, r};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [26:0] act, input logic [26:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%07h expected 0x%07h", nm, act, exp);
        end
    endtask

    // Monitor: pulse counting, completion scoreboard, snapshot checks, RX model drive.
    always @(negedge clk) begin
        tog = ~tog;
        for (int g = 0; g < 2; g++) begin
            if (rstv[g]) begin
                mv[g] = 0; ld[g] = 0; cl[g] = 0; mtap[g] = 0;
                prev_end[g] = 1'b0;
            end else begin
                if (snapv[g][23]) begin ld[g]++; mtap[g] = 0; end
                if (snapv[g][22]) begin mv[g]++; mtap[g]++; end
                if (snapv[g][21]) cl[g]++;
                if (int'(snapv[g][23]) + int'(snapv[g][22]) + int'(snapv[g][21]) > 1)
                    multi_err = 1'b1;
                if ((snapv[g][25] | snapv[g][24]) && !prev_end[g]) begin
                    if (g == 0 && cq0.size() > 0) begin
                        e_m = cq0.pop_front();
                    end else if (g == 1 && cq1.size() > 0) begin
                        e_m = cq1.pop_front();
                    end else begin
                        e_m.name = "unexpected_end";
                        e_m.done = 1'b0; e_m.fail = 1'b0; e_m.tap = 8'd0; e_m.edg = 8'd0;
                        e_m.moves = -1; e_m.loads = -1; e_m.clears = -1;
                    end
                    chk({e_m.name, ".done"},   int'(snapv[g][25]),    int'(e_m.done));
                    chk({e_m.name, ".fail"},   int'(snapv[g][24]),    int'(e_m.fail));
                    chk({e_m.name, ".busy"},   int'(snapv[g][26]),    0);
                    chk({e_m.name, ".tap"},    int'(snapv[g][15:8]),  int'(e_m.tap));
                    chk({e_m.name, ".edge"},   int'(snapv[g][7:0]),   int'(e_m.edg));
                    chk({e_m.name, ".moves"},  mv[g], e_m.moves);
                    chk({e_m.name, ".loads"},  ld[g], e_m.loads);
                    chk({e_m.name, ".clears"}, cl[g], e_m.clears);
                    mv[g] = 0; ld[g] = 0; cl[g] = 0;
                end
                prev_end[g] = snapv[g][25] | snapv[g][24];
            end
        end
        while (sq.size() > 0) begin
            s_m = sq.pop_front();
            chkv(s_m.name, snapv[s_m.inst], s_m.vec);
        end
        rx_m = model0(m0, mtap[0], tog);
        ifc0.EYE_MONITOR_EARLY_0       = rx_m[2];
        ifc0.EYE_MONITOR_LATE_0        = rx_m[1];
        ifc0.RX_DATA_0                 = {tog, rx_m[0]};
        ifc0.DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
        ifc1.EYE_MONITOR_EARLY_0       = 1'b0;
        ifc1.EYE_MONITOR_LATE_0        = 1'b0;
        ifc1.RX_DATA_0                 = {tog, 1'b0};
        ifc1.DELAY_LINE_OUT_OF_RANGE_0 = (m1 == 1) && (mtap[1] >= 7);
        if (fin_req) begin
            chk("sb_empty0", cq0.size(), 0);
            chk("sb_empty1", cq1.size(), 0);
            chk("pulse_exclusive", int'(multi_err), 0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic push_snap(input string nm, input int inst, input logic [26:0] vec);
        snap_t s;
        s.name = nm; s.inst = inst; s.vec = vec;
        sq.push_back(s);
    endtask

    task automatic wait_end(input int g, input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            n++;
            if (snapv[g][25] | snapv[g][24]) break;
        end
        #1;
    endtask

    // Issues one sweep on lane g and queues its expected completion.
    task automatic run(input int g, input string nm, input int mode, input logic done, input logic fail,
                       input logic [7:0] tap, input logic [7:0] edg, input int moves, input int clears,
                       input logic [7:0] tap_before, input logic [7:0] edge_before);
        exp_t e;
        e.name = nm; e.done = done; e.fail = fail; e.tap = tap; e.edg = edg;
        e.moves = moves; e.loads = 1; e.clears = clears;
        if (g == 0) begin
            m0 = mode; cq0.push_back(e); start0 = 1'b1;
        end else begin
            m1 = mode; cq1.push_back(e); start1 = 1'b1;
        end
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        push_snap({nm, ".load"}, g, mk(1'b1, 1'b0, 1'b0, 1'b1, tap_before, edge_before));
        if (g == 0) begin
            repeat (20) @(posedge clk);
            #1 start0 = 1'b1;
            @(posedge clk);
            #1 start0 = 1'b0;
        end
        wait_end(g, 3000);
    endtask

    initial begin
        int n;
        rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst0 = 1'b0; rst1 = 1'b0;
        push_snap("reset0", 0, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0));
        push_snap("reset1", 1, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0));
        @(posedge clk);
        #1;

        run(0, "edge5",  1, 1'b1, 1'b0, 8'd5,  8'd5,  5,  6,  8'd0, 8'd0);
        run(0, "noise",  2, 1'b1, 1'b0, 8'd6,  8'd6,  6,  7,  8'd5, 8'd5);
        run(0, "high",   3, 1'b1, 1'b0, 8'd20, 8'd20, 20, 21, 8'd6, 8'd6);

        m0 = 1;
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        n = 0;
        while (mtap[0] != 3 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (14) @(posedge clk);
        #1 rst0 = 1'b1;
        @(posedge clk);
        #1 rst0 = 1'b0;
        push_snap("rst_mid", 0, mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0));
        @(posedge clk);
        #1;
        run(0, "restart", 1, 1'b1, 1'b0, 8'd5, 8'd5, 5, 6, 8'd0, 8'd0);

        run(1, "noedge", 0, 1'b0, 1'b1, 8'd15, 8'd0, 15, 16, 8'd0,  8'd0);
        run(1, "oor",    1, 1'b0, 1'b1, 8'd7,  8'd0, 7,  8,  8'd15, 8'd0);

        repeat (3) @(posedge clk);
        #1 fin_req = 1'b1;
        repeat (10) @(posedge clk);
        $display("FAIL watchdog: monitor did not reach summary");
        $fatal(1);
    end

endmodule
`default_nettype wire
